queen_safety_scanner: RTL and testbench
=======================================

QUEEN_SAFETY_SCANNER -- requirements
Module: queen_safety_scanner

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-high.
REQ-002 Port: clk  in  1  clock; all state updates occur on its rising edge.
REQ-003 Port: rst  in  1  asynchronous active-high reset.
REQ-004 Port: wr_en  in  1  board-table write strobe; sampled on the clk edge.
REQ-005 Port: fill_erase  in  1  write type: 1 = place a queen, 0 = remove a queen.
REQ-006 Port: wr_row  in  3  row index (0-7) of the write.
REQ-007 Port: wr_col  in  3  column index (0-7) of a place write.
REQ-008 Port: check_start  in  1  request a safety check of the candidate square.
REQ-009 Port: cand_row  in  3  candidate row; latched when check_start is accepted.
REQ-010 Port: cand_col  in  3  candidate column; latched when check_start is accepted.
REQ-011 Port: busy  out  1  high in the SCAN and DONE states.
REQ-012 Port: check_done  out  1  one-cycle pulse; result is valid.
REQ-013 Port: safe_or_not  out  1  1 = candidate conflicts with no placed queen.
REQ-014 Port: queen_count  out  4  number of valid table entries (0-8).

Function
REQ-015 The block SHALL hold an 8-entry table: per row, a valid bit and a 3-bit column.
REQ-016 A place write (wr_en=1, fill_erase=1) SHALL set valid[wr_row] and col[wr_row]=wr_col; queen_count SHALL increment only if the entry was invalid.
REQ-017 A place write to a row that is already valid SHALL overwrite the column, and queen_count SHALL remain unchanged.
REQ-018 An erase write (wr_en=1, fill_erase=0) SHALL clear valid[wr_row] and decrement queen_count; an erase of an invalid row SHALL have no effect.
REQ-019 Writes SHALL be accepted only in IDLE; wr_en asserted while busy=1 SHALL be ignored.
REQ-020 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-021 In IDLE, check_start=1 at an edge SHALL latch cand_row and cand_col, set scan_row=0, and enter SCAN.
REQ-022 check_start SHALL be ignored outside IDLE.
REQ-023 If check_start and wr_en occur in the same IDLE cycle, the write SHALL be applied and the scan SHALL see the written value.
REQ-024 Each SCAN cycle SHALL evaluate table row scan_row, where conflict = valid & (scan_row != cand_row) & (col == cand_col | |scan_row - cand_row| == |col - cand_col|).
REQ-025 The absolute differences in REQ-024 SHALL be computed unsigned on 3 bits with no wrap-around (|a-b| = a>=b ? a-b : b-a).
REQ-026 On a SCAN edge: if conflict, the FSM SHALL go to DONE with safe=0; else if scan_row==7, it SHALL go to DONE with safe=1; otherwise scan_row SHALL increment.
REQ-027 In DONE, check_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-028 Latency: a conflict-free check SHALL assert check_done in cycle 9 after the accepting edge; a check whose first conflict is at row r SHALL assert it in cycle r+2.
REQ-029 safe_or_not SHALL be updated on entry to DONE and held until the next DONE; it SHALL be meaningful only when check_done is 1.
REQ-030 A candidate's own row SHALL never cause a conflict, whether or not that row is valid.
REQ-031 With an empty table, a check SHALL return safe_or_not=1.

Reset
REQ-032 While rst=1: state=IDLE, all valid bits=0, scan_row=0, busy=0, check_done=0, safe_or_not=0, queen_count=0.
REQ-033 A reset asserted mid-SCAN SHALL abort the check with no check_done pulse, and all table contents SHALL be lost.
REQ-034 The first check_start SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-035 Empty table; check (3,4) -> check_done 9 cycles after start, safe_or_not=1, queen_count=0.
REQ-036 Place (0,0); check (1,1) -> diagonal conflict at row 0, check_done 2 cycles after start, safe=0. Check (1,2) -> safe=1 at cycle 9.
REQ-037 Place (5,3); check (2,3) -> column conflict, check_done at cycle 7, safe=0. Erase row 5; check (2,3) -> safe=1, queen_count=0.
REQ-038 Place (4,6) twice, then (4,1) -> queen_count=1; check (7,4) -> anti-diagonal conflict at row 4 (|3|==|3|), safe=0 at cycle 6.
REQ-039 Issue check_start, then wr_en and a second check_start during SCAN -> both are ignored, there is exactly one check_done, and the table is unchanged.
REQ-040 Assert rst at cycle 3 of SCAN -> no check_done pulse, busy=0 and queen_count=0 immediately, and a new check accepted after release returns safe=1.

Source files
------------

// File: rtl/queen_safety_scanner_if.sv
// Bundle of the board-write, check-request and result signals of the queen safety scanner.
interface queen_safety_scanner_if;
  logic       wr_en;
  logic       fill_erase;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic       check_start;
  logic [2:0] cand_row;
  logic [2:0] cand_col;
  logic       busy;
  logic       check_done;
  logic       safe_or_not;
  logic [3:0] queen_count;

  modport master (
    output wr_en, fill_erase, wr_row, wr_col, check_start, cand_row, cand_col,
    input  busy, check_done, safe_or_not, queen_count
  );

  modport slave (
    input  wr_en, fill_erase, wr_row, wr_col, check_start, cand_row, cand_col,
    output busy, check_done, safe_or_not, queen_count
  );
endinterface

// File: rtl/queen_safety_scanner.sv
// Eight-row queen table with a row-serial scanner that reports whether a candidate
// square is attacked by any placed queen.
module queen_safety_scanner (
  input  logic                    clk,
  input  logic                    rst,
  queen_safety_scanner_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_reg;
  logic [2:0] scan_row_reg;
  logic [2:0] cand_row_reg;
  logic [2:0] cand_col_reg;
  logic [3:0] count_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       safe_reg;

  logic [7:0] valid_w;
  logic [2:0] col_w [8];
  logic       wr_ok;

  // Writes only land while idle, so a scan always sees a stable table.
  assign wr_ok = bus.wr_en && (state_reg == IDLE);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      logic       valid_reg;
      logic [2:0] col_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (wr_ok && (bus.wr_row == 3'(gi))) begin
          valid_reg <= bus.fill_erase;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_ok && bus.fill_erase && (bus.wr_row == 3'(gi))) begin
          col_reg <= bus.wr_col;
        end
      end

      assign valid_w[gi] = valid_reg;
      assign col_w[gi]   = col_reg;
    end
  endgenerate

  logic [2:0] row_col;
  logic [2:0] dr;
  logic [2:0] dc;
  logic       conflict;

  always_comb begin
    row_col  = col_w[scan_row_reg];
    dr       = (scan_row_reg >= cand_row_reg) ? (scan_row_reg - cand_row_reg)
                                              : (cand_row_reg - scan_row_reg);
    dc       = (row_col >= cand_col_reg) ? (row_col - cand_col_reg)
                                         : (cand_col_reg - row_col);
    conflict = valid_w[scan_row_reg] && (scan_row_reg != cand_row_reg) &&
               ((row_col == cand_col_reg) || (dr == dc));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 4'd0;
    end else if (wr_ok) begin
      if (bus.fill_erase && !valid_w[bus.wr_row]) begin
        count_reg <= count_reg + 4'd1;
      end else if (!bus.fill_erase && valid_w[bus.wr_row]) begin
        count_reg <= count_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      scan_row_reg <= 3'd0;
      cand_row_reg <= 3'd0;
      cand_col_reg <= 3'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      safe_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.check_start) begin
            cand_row_reg <= bus.cand_row;
            cand_col_reg <= bus.cand_col;
            scan_row_reg <= 3'd0;
            busy_reg     <= 1'b1;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          if (conflict) begin
            safe_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (scan_row_reg == 3'd7) begin
            safe_reg  <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            scan_row_reg <= scan_row_reg + 3'd1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.check_done  = done_reg;
  assign bus.safe_or_not = safe_reg;
  assign bus.queen_count = count_reg;
endmodule

// File: tb/tb_queen_safety_scanner.sv
// Directed bench for queen_safety_scanner: table writes, check latency/result, busy gating, reset abort.
module tb_queen_safety_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  queen_safety_scanner_if bus ();

  queen_safety_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic fill, input logic [2:0] row, input logic [2:0] col);
    bus.wr_en      = 1'b1;
    bus.fill_erase = fill;
    bus.wr_row     = row;
    bus.wr_col     = col;
    @(posedge clk); #1;
    bus.wr_en      = 1'b0;
  endtask

  // Starts a check at the next edge and waits for check_done; cycle n follows edge n-1.
  task automatic do_check(input string tag, input logic [2:0] r, input logic [2:0] c,
                          input logic exp_safe, input int exp_cycle);
    logic found;
    int   n;
    bus.cand_row    = r;
    bus.cand_col    = c;
    bus.check_start = 1'b1;
    @(posedge clk); #1;
    bus.check_start = 1'b0;
    bus.wr_en       = 1'b0;
    chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
    found = 1'b0;
    n     = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.check_done) begin
        found = 1'b1;
        n     = i;
      end
    end
    chk({tag, "_done_seen"}, 8'(found), 8'd1);
    if (found) begin
      chk({tag, "_cycle"}, 8'(n + 1), 8'(exp_cycle));
      chk({tag, "_safe"}, 8'(bus.safe_or_not), 8'(exp_safe));
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, 8'(bus.check_done), 8'd0);
      chk({tag, "_idle"}, 8'(bus.busy), 8'd0);
    end
  endtask

  initial begin
    int pulses;
    logic first_safe;
    bus.wr_en       = 1'b0;
    bus.fill_erase  = 1'b0;
    bus.wr_row      = 3'd0;
    bus.wr_col      = 3'd0;
    bus.check_start = 1'b0;
    bus.cand_row    = 3'd0;
    bus.cand_col    = 3'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  8'(bus.busy), 8'd0);
    chk("rst_done",  8'(bus.check_done), 8'd0);
    chk("rst_safe",  8'(bus.safe_or_not), 8'd0);
    chk("rst_count", 8'(bus.queen_count), 8'd0);
    rst = 1'b0;

    // Empty table, first check right after reset release.
    do_check("empty", 3'd3, 3'd4, 1'b1, 9);
    chk("empty_count", 8'(bus.queen_count), 8'd0);

    do_write(1'b1, 3'd0, 3'd0);
    chk("p00_count", 8'(bus.queen_count), 8'd1);
    do_check("diag_r0", 3'd1, 3'd1, 1'b0, 2);
    do_check("safe_12", 3'd1, 3'd2, 1'b1, 9);
    do_write(1'b0, 3'd0, 3'd0);
    chk("erase0_count", 8'(bus.queen_count), 8'd0);
    do_write(1'b0, 3'd6, 3'd0);
    chk("erase_invalid_count", 8'(bus.queen_count), 8'd0);

    do_write(1'b1, 3'd5, 3'd3);
    do_check("col_r5", 3'd2, 3'd3, 1'b0, 7);
    do_write(1'b0, 3'd5, 3'd0);
    do_check("after_erase5", 3'd2, 3'd3, 1'b1, 9);
    chk("erase5_count", 8'(bus.queen_count), 8'd0);

    do_write(1'b1, 3'd4, 3'd6);
    do_write(1'b1, 3'd4, 3'd6);
    do_write(1'b1, 3'd4, 3'd1);
    chk("overwrite_count", 8'(bus.queen_count), 8'd1);
    do_check("antidiag_r4", 3'd7, 3'd4, 1'b0, 6);
    do_check("own_row", 3'd4, 3'd1, 1'b1, 9);

    // Same-cycle write and check: scan must see the new row-0 queen.
    bus.wr_en      = 1'b1;
    bus.fill_erase = 1'b1;
    bus.wr_row     = 3'd0;
    bus.wr_col     = 3'd5;
    do_check("wr_and_check", 3'd3, 3'd2, 1'b0, 2);
    chk("wr_and_check_count", 8'(bus.queen_count), 8'd2);
    do_write(1'b0, 3'd0, 3'd0);
    chk("erase0b_count", 8'(bus.queen_count), 8'd1);

    // Write and re-start while scanning are both dropped.
    bus.cand_row    = 3'd0;
    bus.cand_col    = 3'd0;
    bus.check_start = 1'b1;
    @(posedge clk); #1;
    bus.wr_en       = 1'b1;
    bus.fill_erase  = 1'b1;
    bus.wr_row      = 3'd2;
    bus.wr_col      = 3'd2;
    bus.cand_row    = 3'd7;
    bus.cand_col    = 3'd7;
    pulses     = 0;
    first_safe = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.check_done) pulses++;
    end
    bus.wr_en       = 1'b0;
    bus.check_start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.check_done) begin
        pulses++;
        first_safe = bus.safe_or_not;
      end
    end
    chk("busy_ignore_pulses", 8'(pulses), 8'd1);
    chk("busy_ignore_safe", 8'(first_safe), 8'd1);
    chk("busy_ignore_count", 8'(bus.queen_count), 8'd1);
    do_check("table_unchanged", 3'd3, 3'd3, 1'b1, 9);

    // Reset in the middle of a scan.
    bus.cand_row    = 3'd0;
    bus.cand_col    = 3'd0;
    bus.check_start = 1'b1;
    @(posedge clk); #1;
    bus.check_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 8'(bus.busy), 8'd0);
    chk("abort_count", 8'(bus.queen_count), 8'd0);
    chk("abort_done", 8'(bus.check_done), 8'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.check_done) pulses++;
    end
    chk("abort_no_pulse", 8'(pulses), 8'd0);
    rst = 1'b0;
    do_check("after_abort", 3'd2, 3'd2, 1'b1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
